pc_stack: RTL and testbench
===========================

Name: pc_stack

Overview:
- Program counter and subroutine/interrupt return stack for the MiniRISC CPU v2.0 core.
- Sits directly downstream of the datapath: consumes its jump_address for JMP/CALL/branches.
- Supplies the instruction-fetch address to program memory.
- Saves and restores {PC, Z/C/N/V flags, IE} for CALL/RTS and interrupt entry/RTI; the controller drives the strobes.

Parameters:
- STACK_DEPTH, 16, number of return-stack entries (power of two, 2..256).
- PC_WIDTH, 8, program counter width (matches jump_address).
- RESET_PC, 8'h00, PC value after reset.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- pc_inc  in  1  fetch step: pc <= pc+1.
- pc_load  in  1  jump: pc <= jump_address.
- jump_address  in  PC_WIDTH  target address from datapath.
- push  in  1  push {pc, flags_in, ie_in} (CALL / interrupt entry).
- pop  in  1  pop top entry into pc (RTS / RTI).
- flags_in  in  4  {Z,C,N,V} from datapath ALU flags.
- ie_in  in  1  current interrupt-enable bit.
- dbg_is_brk  in  1  breakpoint state: freezes all normal updates.
- dbg_pc_wr  in  1  debug PC write, honoured only while dbg_is_brk=1.
- dbg_data_in  in  PC_WIDTH  debug write data.
- err_clr  in  1  clears sticky error flags.
- pc  out  PC_WIDTH  current program counter, registered.
- top_flags  out  4  flags field of top entry, combinational from stack[sp-1]; 0 when empty.
- top_ie  out  1  IE field of top entry, combinational; 0 when empty.
- stack_empty  out  1  sp==0.
- stack_full  out  1  sp==STACK_DEPTH.
- ovf_err  out  1  sticky: push attempted while full.
- unf_err  out  1  sticky: pop attempted while empty.

Behaviour:
- Reset (async, rst_n=0): pc=RESET_PC, sp=0, ovf_err=0, unf_err=0. Stack RAM contents are not reset. top_* read 0 because the stack is empty.
- Reset assertion mid-operation aborts any push/pop immediately. No partial state survives.
- sp is a counter of width log2(STACK_DEPTH)+1. Entries are stored at stack[sp]; push then increments sp, pop decrements it.
- PC update priority, highest first:
  - (1) dbg_is_brk=1: only dbg_pc_wr acts (pc <= dbg_data_in). push, pop, pc_inc, pc_load and sp are all frozen. err_clr still acts.
  - (2) pop: pc <= stack[sp-1].pc.
  - (3) pc_load: pc <= jump_address.
  - (4) pc_inc: pc <= pc+1, modulo 2^PC_WIDTH (8'hFF -> 8'h00, no flag).
  - (5) otherwise pc holds.
- CALL / interrupt entry = push and pc_load in the same cycle. The stored pc is the pre-edge pc, i.e. the return address the controller has already stepped past. The new pc is jump_address. Single cycle.
- pc_inc together with pc_load: load wins.
- push and pop in the same cycle: illegal. Pop executes and push is ignored; no error flag is set.
- Push while full: entry not written, sp unchanged, ovf_err <= 1. An accompanying pc_load still takes effect.
- Pop while empty: pc unchanged (pc_inc/pc_load in the same cycle are then honoured per priority), sp unchanged, unf_err <= 1.
- Restoring flags and IE on RTI is done by the controller. It samples top_flags/top_ie in the same cycle it asserts pop, then writes them via the datapath flag_din/flag_wr path. This block only stores and presents them.
- Latency: every control input is sampled on the rising edge; pc, sp, stack_empty/full and error flags are valid in the next cycle.
- err_clr clears both sticky flags. A new error in the same cycle takes priority over err_clr (flag stays 1).

Test Plan:
- Reset, then pc_inc for 3 cycles -> pc = 0,1,2,3. Hold pc=8'hFF and pulse pc_inc -> pc=8'h00.
- pc=8'h10, push+pc_load with jump_address=8'h40, flags_in=4'b1010, ie_in=1 -> pc=8'h40, sp=1, top_flags=4'b1010, top_ie=1. pop -> pc=8'h10, stack_empty=1.
- 16 nested calls (return addresses 8'h00..8'h0F) -> stack_full=1. 17th push+load (jump_address=8'h80) -> pc=8'h80, ovf_err=1, sp=16. 16 pops return 8'h0F..8'h00 in LIFO order.
- Pop on an empty stack with pc=8'h22 -> pc=8'h22, unf_err=1. err_clr -> unf_err=0.
- dbg_is_brk=1 with pc_inc, push and pop all asserted -> pc and sp unchanged. dbg_pc_wr with dbg_data_in=8'h5A -> pc=8'h5A.
- Assert rst_n=0 between clock edges while push+pc_load is pending -> pc=RESET_PC immediately, sp=0, stack_empty=1, errors 0.

Source files
------------

// File: rtl/pc_stack_if.sv
// Control/status bundle between the MiniRISC controller/datapath and the
// program-counter / return-stack block.
interface pc_stack_if #(
    parameter int PC_WIDTH = 8
);
    logic                pc_inc;
    logic                pc_load;
    logic [PC_WIDTH-1:0] jump_address;
    logic                push;
    logic                pop;
    logic [3:0]          flags_in;
    logic                ie_in;
    logic                dbg_is_brk;
    logic                dbg_pc_wr;
    logic [PC_WIDTH-1:0] dbg_data_in;
    logic                err_clr;

    logic [PC_WIDTH-1:0] pc;
    logic [3:0]          top_flags;
    logic                top_ie;
    logic                stack_empty;
    logic                stack_full;
    logic                ovf_err;
    logic                unf_err;

    modport master (
        output pc_inc, pc_load, jump_address, push, pop, flags_in, ie_in,
               dbg_is_brk, dbg_pc_wr, dbg_data_in, err_clr,
        input  pc, top_flags, top_ie, stack_empty, stack_full, ovf_err, unf_err
    );

    modport slave (
        input  pc_inc, pc_load, jump_address, push, pop, flags_in, ie_in,
               dbg_is_brk, dbg_pc_wr, dbg_data_in, err_clr,
        output pc, top_flags, top_ie, stack_empty, stack_full, ovf_err, unf_err
    );
endinterface

// File: rtl/pc_stack.sv
// MiniRISC program counter plus return stack holding {pc, Z/C/N/V, IE}
// for CALL/RTS and interrupt entry/RTI.
module pc_stack #(
    parameter int                  STACK_DEPTH = 16,
    parameter int                  PC_WIDTH    = 8,
    parameter logic [PC_WIDTH-1:0] RESET_PC    = '0
) (
    input logic       clk,
    input logic       rst_n,
    pc_stack_if.slave bus
);
    localparam int ADDR_W  = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    localparam int SP_W    = ADDR_W + 1;
    localparam int ENTRY_W = PC_WIDTH + 5;
    localparam logic [SP_W-1:0]     SP_ONE  = 1;
    localparam logic [SP_W-1:0]     SP_FULL = SP_W'(STACK_DEPTH);
    localparam logic [PC_WIDTH-1:0] PC_ONE  = 1;

    logic [ENTRY_W-1:0]  stack_mem [STACK_DEPTH];

    logic [PC_WIDTH-1:0] pc_reg, pc_next;
    logic [SP_W-1:0]     sp_reg, sp_next;
    logic                ovf_reg, ovf_next;
    logic                unf_reg, unf_next;

    logic                stack_empty, stack_full;
    logic [ADDR_W-1:0]   top_idx, wr_idx;
    logic [ENTRY_W-1:0]  top_entry;
    logic [PC_WIDTH-1:0] seq_pc;
    logic                do_push, set_ovf, set_unf;

    assign stack_empty = (sp_reg == '0);
    assign stack_full  = (sp_reg == SP_FULL);
    assign top_idx     = ADDR_W'(sp_reg - SP_ONE);
    assign wr_idx      = ADDR_W'(sp_reg);
    assign top_entry   = stack_mem[top_idx];

    // Sequential PC when no pop or debug access owns the update: load beats increment.
    assign seq_pc = bus.pc_load ? bus.jump_address :
                    bus.pc_inc  ? pc_reg + PC_ONE  : pc_reg;

    always_comb begin
        pc_next  = pc_reg;
        sp_next  = sp_reg;
        ovf_next = ovf_reg;
        unf_next = unf_reg;
        do_push  = 1'b0;
        set_ovf  = 1'b0;
        set_unf  = 1'b0;

        if (bus.dbg_is_brk) begin
            if (bus.dbg_pc_wr) begin
                pc_next = bus.dbg_data_in;
            end
        end else if (bus.pop) begin
            // A simultaneous push is dropped silently; pop owns the cycle.
            if (stack_empty) begin
                set_unf = 1'b1;
                pc_next = seq_pc;
            end else begin
                pc_next = top_entry[ENTRY_W-1 -: PC_WIDTH];
                sp_next = sp_reg - SP_ONE;
            end
        end else begin
            if (bus.push) begin
                if (stack_full) begin
                    set_ovf = 1'b1;
                end else begin
                    do_push = 1'b1;
                    sp_next = sp_reg + SP_ONE;
                end
            end
            pc_next = seq_pc;
        end

        if (bus.err_clr) begin
            ovf_next = 1'b0;
            unf_next = 1'b0;
        end
        if (set_ovf) ovf_next = 1'b1;
        if (set_unf) unf_next = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_reg  <= RESET_PC;
            sp_reg  <= '0;
            ovf_reg <= 1'b0;
            unf_reg <= 1'b0;
        end else begin
            pc_reg  <= pc_next;
            sp_reg  <= sp_next;
            ovf_reg <= ovf_next;
            unf_reg <= unf_next;
        end
    end

    // Storage is not reset; rst_n gating keeps a push racing reset from landing.
    always_ff @(posedge clk) begin
        if (rst_n && do_push) begin
            stack_mem[wr_idx] <= {pc_reg, bus.flags_in, bus.ie_in};
        end
    end

    assign bus.pc          = pc_reg;
    assign bus.top_flags   = stack_empty ? 4'b0000 : top_entry[4:1];
    assign bus.top_ie      = stack_empty ? 1'b0    : top_entry[0];
    assign bus.stack_empty = stack_empty;
    assign bus.stack_full  = stack_full;
    assign bus.ovf_err     = ovf_reg;
    assign bus.unf_err     = unf_reg;
endmodule

// File: tb/tb_pc_stack.sv
// Scoreboard bench for pc_stack: driver pushes expected post-edge state from a
// queue-based reference model, monitor pops and compares after each edge.
module tb_pc_stack;
    localparam int DEPTH = 16;

    typedef struct packed {
        logic [7:0] pc;
        logic [3:0] tf;
        logic       tie;
        logic       emp;
        logic       ful;
        logic       ovf;
        logic       unf;
    } obs_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic next_rst_n = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;
    int   cyc = 0;

    obs_t exp_q[$];

    // Reference model: the return stack is a plain queue of {pc, flags, ie}.
    logic [7:0]  m_pc;
    logic [12:0] m_stack[$];
    logic        m_ovf, m_unf;

    pc_stack_if #(.PC_WIDTH(8)) bus ();

    pc_stack #(.STACK_DEPTH(DEPTH), .PC_WIDTH(8), .RESET_PC(8'h00)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    function automatic obs_t expected();
        obs_t e;
        e.pc  = m_pc;
        e.tf  = (m_stack.size() > 0) ? m_stack[m_stack.size()-1][4:1] : 4'b0000;
        e.tie = (m_stack.size() > 0) ? m_stack[m_stack.size()-1][0]   : 1'b0;
        e.emp = (m_stack.size() == 0);
        e.ful = (m_stack.size() == DEPTH);
        e.ovf = m_ovf;
        e.unf = m_unf;
        return e;
    endfunction

    function automatic obs_t actual();
        obs_t a;
        a = {bus.pc, bus.top_flags, bus.top_ie, bus.stack_empty,
             bus.stack_full, bus.ovf_err, bus.unf_err};
        return a;
    endfunction

    task automatic check(input obs_t e, input string name);
        obs_t a;
        a = actual();
        n_vec++;
        if (a !== e) begin
            n_err++;
            $display("FAIL %s cyc=%0d got pc=%h tf=%b ie=%b emp=%b ful=%b ovf=%b unf=%b want pc=%h tf=%b ie=%b emp=%b ful=%b ovf=%b unf=%b",
                     name, cyc, a.pc, a.tf, a.tie, a.emp, a.ful, a.ovf, a.unf,
                     e.pc, e.tf, e.tie, e.emp, e.ful, e.ovf, e.unf);
        end else begin
            $display("cyc=%0d %s pc=%h top=%b/%b emp=%b ful=%b ovf=%b unf=%b",
                     cyc, name, a.pc, a.tf, a.tie, a.emp, a.ful, a.ovf, a.unf);
        end
    endtask

    task automatic model_reset();
        m_pc  = 8'h00;
        m_stack.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
    endtask

    task automatic model_step(input logic inc, input logic ld, input logic [7:0] ja,
                              input logic psh, input logic pp, input logic [3:0] fl,
                              input logic ie, input logic brk, input logic dw,
                              input logic [7:0] dd, input logic clr);
        logic [7:0]  seq;
        logic [12:0] ent;
        logic        so, su;
        so  = 1'b0;
        su  = 1'b0;
        seq = ld ? ja : (inc ? m_pc + 8'd1 : m_pc);
        if (brk) begin
            if (dw) m_pc = dd;
        end else if (pp) begin
            if (m_stack.size() == 0) begin
                su   = 1'b1;
                m_pc = seq;
            end else begin
                ent  = m_stack.pop_back();
                m_pc = ent[12:5];
            end
        end else begin
            if (psh) begin
                if (m_stack.size() == DEPTH) so = 1'b1;
                else m_stack.push_back({m_pc, fl, ie});
            end
            m_pc = seq;
        end
        m_ovf = so ? 1'b1 : (clr ? 1'b0 : m_ovf);
        m_unf = su ? 1'b1 : (clr ? 1'b0 : m_unf);
    endtask

    task automatic step(input logic inc, input logic ld, input logic [7:0] ja,
                        input logic psh, input logic pp, input logic [3:0] fl,
                        input logic ie, input logic brk, input logic dw,
                        input logic [7:0] dd, input logic clr);
        @(negedge clk);
        rst_n            = next_rst_n;
        bus.pc_inc       = inc;
        bus.pc_load      = ld;
        bus.jump_address = ja;
        bus.push         = psh;
        bus.pop          = pp;
        bus.flags_in     = fl;
        bus.ie_in        = ie;
        bus.dbg_is_brk   = brk;
        bus.dbg_pc_wr    = dw;
        bus.dbg_data_in  = dd;
        bus.err_clr      = clr;
        if (!rst_n) model_reset();
        else model_step(inc, ld, ja, psh, pp, fl, ie, brk, dw, dd, clr);
        exp_q.push_back(expected());
    endtask

    task automatic idle();                 step(0,0,8'h00,0,0,4'h0,0,0,0,8'h00,0); endtask
    task automatic do_inc();               step(1,0,8'h00,0,0,4'h0,0,0,0,8'h00,0); endtask
    task automatic do_load(input logic [7:0] a); step(0,1,a,0,0,4'h0,0,0,0,8'h00,0); endtask
    task automatic do_call(input logic [7:0] a, input logic [3:0] f, input logic ie);
        step(0,1,a,1,0,f,ie,0,0,8'h00,0);
    endtask
    task automatic do_pop();               step(0,0,8'h00,0,1,4'h0,0,0,0,8'h00,0); endtask
    task automatic do_clr();               step(0,0,8'h00,0,0,4'h0,0,0,0,8'h00,1); endtask

    // Monitor: one comparison per rising edge for which the driver queued a result.
    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            #2;
            if (exp_q.size() > 0) check(exp_q.pop_front(), "edge");
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog cyc=%0d got no completion want finish", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.pc_inc = 0; bus.pc_load = 0; bus.jump_address = 0; bus.push = 0;
        bus.pop = 0; bus.flags_in = 0; bus.ie_in = 0; bus.dbg_is_brk = 0;
        bus.dbg_pc_wr = 0; bus.dbg_data_in = 0; bus.err_clr = 0;
        model_reset();

        idle();
        idle();
        next_rst_n = 1'b1;

        // Counting and wrap
        repeat (3) do_inc();
        do_load(8'hFF);
        do_inc();

        // Single call / return
        do_load(8'h10);
        do_call(8'h40, 4'b1010, 1'b1);
        do_pop();

        // Fill, overflow, LIFO unwind
        for (int i = 0; i < DEPTH; i++) begin
            do_load(8'(i));
            do_call(8'h30, 4'(i), i[0]);
        end
        do_call(8'h80, 4'hF, 1'b1);
        for (int i = 0; i < DEPTH; i++) do_pop();
        do_clr();

        // Underflow, then pop-empty with load still honoured
        do_load(8'h22);
        do_pop();
        do_clr();
        step(0,1,8'h33,0,1,4'h0,0,0,0,8'h00,0);
        do_clr();

        // Breakpoint freeze and debug write
        do_call(8'h50, 4'b0110, 1'b0);
        step(1,0,8'h00,1,1,4'h3,1,1,0,8'h00,0);
        step(1,1,8'h99,0,1,4'h0,0,1,1,8'h5A,0);
        step(1,0,8'h00,0,0,4'h0,0,0,1,8'hA5,0);
        do_pop();

        // Push+pop together: pop wins, no flag
        do_call(8'h60, 4'b1100, 1'b1);
        step(0,0,8'h00,1,1,4'h5,1,0,0,8'h00,0);

        // Randomised: push-biased half, then pop-biased half
        for (int n = 0; n < 2000; n++) begin
            logic brk, inc, ld, psh, pp, dw, clr;
            brk = ($urandom_range(0, 99) < 5);
            inc = 1'($urandom);
            ld  = ($urandom_range(0, 3) == 0);
            psh = (n < 1000) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 4) == 0);
            pp  = (n < 1000) ? ($urandom_range(0, 4) == 0) : ($urandom_range(0, 2) == 0);
            dw  = 1'($urandom);
            clr = ($urandom_range(0, 15) == 0);
            step(inc, ld, 8'($urandom), psh, pp, 4'($urandom), 1'($urandom),
                 brk, dw, 8'($urandom), clr);
        end

        // Async reset between edges while a push+load is pending
        do_call(8'h70, 4'b0001, 1'b1);
        @(negedge clk);
        bus.push = 1; bus.pc_load = 1; bus.jump_address = 8'h77;
        bus.pc_inc = 0; bus.pop = 0; bus.dbg_is_brk = 0; bus.err_clr = 0;
        #1 rst_n = 1'b0;
        model_reset();
        exp_q.push_back(expected());
        #1 check(expected(), "async_reset");
        idle();
        do_inc();
        do_pop();

        @(posedge clk);
        #3;
        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain got %0d pending want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
